// File: rtl/freq_meter.sv
// Frequency and period meter for an asynchronous square wave: counts rising edges
// per gate window and measures the clock-cycle distance between consecutive edges.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int N_CNT       = 28
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_signal,
  output logic [N_CNT-1:0] o_freq,
  output logic             o_freq_valid,
  output logic             o_overflow,
  output logic [N_CNT-1:0] o_period,
  output logic             o_period_valid,
  output logic             o_no_signal
);

  localparam int                N_GATE      = $clog2(GATE_CYCLES);
  localparam logic [N_GATE-1:0] GATE_LAST   = N_GATE'(GATE_CYCLES - 1);
  localparam logic [N_CNT-1:0]  PER_TIMEOUT = N_CNT'(GATE_CYCLES);
  localparam logic [N_CNT-1:0]  CNT_MAX     = '1;

  typedef enum logic {IDLE, ARMED} per_state_t;

  logic sync_meta, sync_sig, sync_prev;
  logic rise;

  logic [N_GATE-1:0] gate_cnt;
  logic [N_CNT-1:0]  edge_cnt, edge_next;
  logic              ovf_flag, ovf_next;
  logic              gate_last;

  per_state_t        state, state_next;
  logic [N_CNT-1:0]  per_cnt, per_cnt_next, period_next;
  logic              period_valid_next, no_signal_next;
  logic              timeout;

  // Two flops tame metastability; the third remembers the last settled level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_meta <= 1'b0;
      sync_sig  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= i_signal;
      sync_sig  <= sync_meta;
      sync_prev <= sync_sig;
    end
  end

  assign rise      = sync_sig & ~sync_prev;
  assign gate_last = (gate_cnt == GATE_LAST);
  assign edge_next = (rise && edge_cnt != CNT_MAX) ? edge_cnt + N_CNT'(1) : edge_cnt;
  assign ovf_next  = ovf_flag | (rise & (edge_cnt == CNT_MAX));

  // A rise in the final gate cycle still belongs to the window that is closing.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      ovf_flag     <= 1'b0;
      o_freq       <= '0;
      o_overflow   <= 1'b0;
      o_freq_valid <= 1'b0;
    end else begin
      o_freq_valid <= 1'b0;
      if (gate_last) begin
        gate_cnt     <= '0;
        edge_cnt     <= '0;
        ovf_flag     <= 1'b0;
        o_freq       <= edge_next;
        o_overflow   <= ovf_next;
        o_freq_valid <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + N_GATE'(1);
        edge_cnt <= edge_next;
        ovf_flag <= ovf_next;
      end
    end
  end

  assign timeout = (per_cnt == PER_TIMEOUT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      per_cnt        <= '0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
      o_no_signal    <= 1'b1;
    end else begin
      state          <= state_next;
      per_cnt        <= per_cnt_next;
      o_period       <= period_next;
      o_period_valid <= period_valid_next;
      o_no_signal    <= no_signal_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (rise) state_next = ARMED;
      ARMED: if (!rise && timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rise on the timeout cycle wins and is taken as an ordinary measurement.
  always_comb begin
    per_cnt_next      = per_cnt;
    period_next       = o_period;
    period_valid_next = o_period_valid;
    no_signal_next    = o_no_signal;
    unique case (state)
      IDLE: begin
        if (rise) begin
          per_cnt_next   = N_CNT'(1);
          no_signal_next = 1'b0;
        end
      end
      ARMED: begin
        if (rise) begin
          period_next       = per_cnt;
          period_valid_next = 1'b1;
          per_cnt_next      = N_CNT'(1);
        end else if (timeout) begin
          period_next       = '0;
          period_valid_next = 1'b0;
          no_signal_next    = 1'b1;
          per_cnt_next      = '0;
        end else begin
          per_cnt_next = per_cnt + N_CNT'(1);
        end
      end
      default: per_cnt_next = '0;
    endcase
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomised scoreboard bench for freq_meter. A second instance uses a gate longer
// than 2^N_CNT edges can fill, so the saturating counter and overflow flag get exercised.
module tb_freq_meter;

  localparam int G1 = 100;
  localparam int N1 = 8;
  localparam int G2 = 200;
  localparam int N2 = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_signal = 1'b0;

  logic [N1-1:0] o_freq, o_period;
  logic          o_freq_valid, o_overflow, o_period_valid, o_no_signal;
  logic [N2-1:0] o_freq2, o_period2;
  logic          o_freq_valid2, o_overflow2, o_period_valid2, o_no_signal2;

  freq_meter #(.GATE_CYCLES(G1), .N_CNT(N1)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_signal(i_signal),
    .o_freq(o_freq), .o_freq_valid(o_freq_valid), .o_overflow(o_overflow),
    .o_period(o_period), .o_period_valid(o_period_valid), .o_no_signal(o_no_signal)
  );

  freq_meter #(.GATE_CYCLES(G2), .N_CNT(N2)) u_dut_sat (
    .i_clk(clk), .i_reset(rst), .i_signal(i_signal),
    .o_freq(o_freq2), .o_freq_valid(o_freq_valid2), .o_overflow(o_overflow2),
    .o_period(o_period2), .o_period_valid(o_period_valid2), .o_no_signal(o_no_signal2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int freq;
    int ovf;
  } freq_exp_t;

  freq_exp_t q1[$];
  freq_exp_t q2[$];

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int k = 0;
  int win1 = 0, win2 = 0;
  int last_rise = 0;
  bit armed = 0;
  bit d1 = 0, d2 = 0, d3 = 0;
  bit rise_now = 0;
  int exp_period = 0, exp_pvalid = 0, exp_nosig = 1;
  int exp_freq = 0, exp_ovf = 0, exp_freq2 = 0, exp_ovf2 = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Reference model: a level sampled at edge k is seen as a rise at edge k+2, windows
  // close on every multiple of the gate length, and a period is the edge-count distance
  // between consecutive rises, abandoned once that distance reaches the gate length.
  always @(posedge clk) begin
    freq_exp_t e;
    cyc++;
    if (rst) begin
      k = 0; win1 = 0; win2 = 0; last_rise = 0; armed = 0;
      d1 = 0; d2 = 0; d3 = 0;
      exp_period = 0; exp_pvalid = 0; exp_nosig = 1;
      exp_freq = 0; exp_ovf = 0; exp_freq2 = 0; exp_ovf2 = 0;
    end else begin
      k++;
      rise_now = d2 & ~d3;
      d3 = d2; d2 = d1; d1 = i_signal;
      if (rise_now) begin
        win1++;
        win2++;
      end
      if (k % G1 == 0) begin
        e.cyc = cyc; e.freq = (win1 > 255) ? 255 : win1; e.ovf = (win1 > 255) ? 1 : 0;
        q1.push_back(e);
        exp_freq = e.freq; exp_ovf = e.ovf;
        win1 = 0;
      end
      if (k % G2 == 0) begin
        e.cyc = cyc; e.freq = (win2 > 63) ? 63 : win2; e.ovf = (win2 > 63) ? 1 : 0;
        q2.push_back(e);
        exp_freq2 = e.freq; exp_ovf2 = e.ovf;
        win2 = 0;
      end
      if (rise_now) begin
        if (armed) begin
          exp_period = k - last_rise;
          exp_pvalid = 1;
        end else begin
          armed = 1;
          exp_nosig = 0;
        end
        last_rise = k;
      end else if (armed && (k - last_rise == G1)) begin
        armed = 0;
        exp_period = 0;
        exp_pvalid = 0;
        exp_nosig = 1;
      end
    end
  end

  // Monitor: pops an expectation whenever a valid pulse appears and flags late or missing pulses.
  always @(posedge clk) begin
    freq_exp_t e;
    #2;
    if (o_freq_valid) begin
      if (q1.size() == 0) checkOutput("freq_valid_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        checkOutput("freq_valid_cycle", cyc, e.cyc);
        checkOutput("freq_value", int'(o_freq), e.freq);
        checkOutput("freq_overflow", int'(o_overflow), e.ovf);
      end
    end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
      checkOutput("freq_valid_missing", 0, 1);
      void'(q1.pop_front());
    end
    if (o_freq_valid2) begin
      if (q2.size() == 0) checkOutput("sat_freq_valid_unexpected", 1, 0);
      else begin
        e = q2.pop_front();
        checkOutput("sat_freq_valid_cycle", cyc, e.cyc);
        checkOutput("sat_freq_value", int'(o_freq2), e.freq);
        checkOutput("sat_freq_overflow", int'(o_overflow2), e.ovf);
      end
    end else if (q2.size() != 0 && q2[0].cyc <= cyc) begin
      checkOutput("sat_freq_valid_missing", 0, 1);
      void'(q2.pop_front());
    end
    checkOutput("period", int'(o_period), exp_period);
    checkOutput("period_valid", int'(o_period_valid), exp_pvalid);
    checkOutput("no_signal", int'(o_no_signal), exp_nosig);
    checkOutput("freq_hold", int'(o_freq), exp_freq);
    checkOutput("overflow_hold", int'(o_overflow), exp_ovf);
    checkOutput("sat_freq_hold", int'(o_freq2), exp_freq2);
    checkOutput("sat_overflow_hold", int'(o_overflow2), exp_ovf2);
  end

  task automatic applyStimulus(input logic level, input int n);
    i_signal = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic driveSquare(input int hi, input int lo, input int n);
    for (int c = 0; c < n; c++) begin
      i_signal = ((c % (hi + lo)) < hi);
      @(negedge clk);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    #1;
    checkOutput("reset_freq", int'(o_freq), 0);
    checkOutput("reset_freq_valid", int'(o_freq_valid), 0);
    checkOutput("reset_overflow", int'(o_overflow), 0);
    checkOutput("reset_period", int'(o_period), 0);
    checkOutput("reset_period_valid", int'(o_period_valid), 0);
    checkOutput("reset_no_signal", int'(o_no_signal), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic lvl;
    int   dur;
    int   n;
    @(negedge clk);
    resetDut();

    $display("[TB] idle low input");
    applyStimulus(1'b0, 250);

    $display("[TB] 10-clock square wave");
    driveSquare(5, 5, 350);

    $display("[TB] input stopped, then restarted");
    applyStimulus(1'b0, 150);
    driveSquare(5, 5, 120);

    $display("[TB] fastest toggle to saturate the long-gate instance");
    driveSquare(1, 1, 450);
    applyStimulus(1'b0, 250);

    $display("[TB] random high/low durations");
    lvl = 1'b0;
    for (int s = 0; s < 60; s++) begin
      lvl = ~lvl;
      dur = ($urandom_range(0, 9) == 0) ? int'($urandom_range(80, 130)) : int'($urandom_range(1, 12));
      applyStimulus(lvl, dur);
    end

    $display("[TB] reset in the middle of a gate window");
    n = (150 - (k % G1)) % G1;
    driveSquare(5, 5, n);
    resetDut();
    driveSquare(5, 5, 300);

    $display("[TB] rise landing in the last gate cycle");
    resetDut();
    applyStimulus(1'b0, 97);
    applyStimulus(1'b1, 150);
    applyStimulus(1'b0, 10);

    checkOutput("queue1_drained", q1.size(), 0);
    checkOutput("queue2_drained", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
